dcd_frame_scheduler: RTL and testbench
======================================

Name: dcd_frame_scheduler

Overview:
- Sequences the DCD emulation datapath per frame: arms on a frame-sync strobe, issues one start pulse to the data sequence generator per row-to-sync strobe, and one start pulse to the switcher/offset recorders per frame.
- Sits between the CLK_80-domain edge-detected strobes and the SEQ_EXT_START inputs of the generator and recorders.
- Counts rows and frames and flags protocol violations.

Parameters:
- ROW_BITS, 10, width of row count and rows-per-frame config.
- FRAME_BITS, 16, width of frame counter (wraps).
- LEN_BITS, 16, width of row-length guard timer.

Ports:
- CLK  in  1  single clock (CLK_80 domain).
- RST  in  1  asynchronous reset, active-high.
- ENABLE  in  1  run enable (level).
- SINGLE_SHOT  in  1  1 = schedule one frame, then stop.
- ROWS_PER_FRAME  in  ROW_BITS  expected rows per frame.
- ROW_LEN  in  LEN_BITS  minimum cycles between row starts; 0 = no guard.
- CLR_ERR  in  1  clears sticky error flags.
- FSYNC_STROBE  in  1  one-cycle frame-sync strobe.
- R2S_STROBE  in  1  one-cycle row-to-sync strobe.
- SEQ_START  out  1  one-cycle start to the data generator.
- REC_START  out  1  one-cycle start to the recorders.
- ROW_CNT  out  ROW_BITS  rows started in the current frame.
- FRAME_CNT  out  FRAME_BITS  completed frames.
- BUSY  out  1  high in ARMED or FRAME.
- DONE  out  1  high in DONE.
- ERR_OVERRUN  out  1  sticky: R2S arrived while the row timer was nonzero.
- ERR_ROWCOUNT  out  1  sticky: frame closed with the wrong row count, or R2S arrived beyond ROWS_PER_FRAME.

Behaviour:
- Reset: state IDLE; all outputs 0; row timer 0; shadow config 0.
- All outputs are registered. SEQ_START and REC_START assert exactly 1 cycle after the causing strobe.
- States:
  - IDLE: ENABLE=1 -> ARMED.
  - ARMED: FSYNC_STROBE -> FRAME. Latch ROWS_PER_FRAME and ROW_LEN into shadow registers, ROW_CNT<=0, pulse REC_START.
  - FRAME:
    - R2S_STROBE with row timer==0 and ROW_CNT<shadow rows: pulse SEQ_START, ROW_CNT++, timer<=shadow ROW_LEN.
    - R2S with timer!=0: no start, no increment, set ERR_OVERRUN.
    - R2S with ROW_CNT==shadow rows: ignored, set ERR_ROWCOUNT.
    - FSYNC_STROBE closes the frame. If ROW_CNT!=shadow rows, set ERR_ROWCOUNT. FRAME_CNT++ (wraps at 2^FRAME_BITS). SINGLE_SHOT=1 -> DONE. Otherwise re-latch the shadow config, ROW_CNT<=0, pulse REC_START, stay in FRAME.
  - DONE: DONE=1; ENABLE=0 -> IDLE.
- ENABLE=0 in ARMED or FRAME -> IDLE next cycle. No starts are issued that cycle or after. ROW_CNT and FRAME_CNT are held; errors are kept; the row timer is cleared.
- Row timer decrements by 1 per cycle while nonzero and saturates at 0.
- Simultaneous FSYNC and R2S (in ARMED or FRAME, not SINGLE_SHOT closing): FSYNC is processed first, then R2S counts as row 0 of the new frame. REC_START and SEQ_START pulse in the same cycle and ROW_CNT=1. The timer check for that R2S is bypassed, because the frame boundary resets the timer.
- SINGLE_SHOT closing with simultaneous R2S: R2S is ignored, with no error.
- Shadow ROWS_PER_FRAME=0: no SEQ_START is ever issued; every R2S sets ERR_ROWCOUNT; a frame close with ROW_CNT=0 is not an error.
- Config changes mid-frame have no effect until the next FSYNC.
- CLR_ERR clears both flags. A set event in the same cycle wins.

Decomposition:
- Shared package: state encoding (IDLE, ARMED, FRAME, DONE) and default widths ROW_BITS/FRAME_BITS/LEN_BITS.
- One natural sub-module: dcd_row_guard_timer (load/decrement/zero-flag counter, LEN_BITS wide).
- The FSM and counters stay in the top module.

Test Plan:
- Reset mid-FRAME with ROW_CNT=5 -> all outputs 0 asynchronously; state IDLE after release.
- ROWS=4, ROW_LEN=0, ENABLE=1. FSYNC, 4x R2S spaced 20 cycles, FSYNC -> REC_START at t+1, 4 SEQ_START pulses each 1 cycle after R2S, second REC_START, FRAME_CNT=1, no errors.
- ROWS=4, ROW_LEN=10. R2S at offsets 0 and 5 -> one SEQ_START, ERR_OVERRUN=1, ROW_CNT=1.
- ROWS=3, send 5 R2S then FSYNC -> 3 SEQ_START, ERR_ROWCOUNT=1. CLR_ERR -> 0. A frame with 2 rows -> ERR_ROWCOUNT=1 at close.
- FSYNC and R2S in the same cycle while in FRAME -> REC_START and SEQ_START in the same cycle, ROW_CNT=1, FRAME_CNT incremented.
- SINGLE_SHOT=1, ROWS=2, full frame -> DONE=1, BUSY=0, further strobes produce no pulses. ENABLE toggled 0->1 -> ARMED again.

Source files
------------

// File: rtl/dcd_frame_scheduler_pkg.sv
// dcd_frame_scheduler_pkg: state encoding and default widths shared by the frame scheduler files
package dcd_frame_scheduler_pkg;
  localparam int ROW_BITS_DEF   = 10;
  localparam int FRAME_BITS_DEF = 16;
  localparam int LEN_BITS_DEF   = 16;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/dcd_row_guard_timer.sv
// dcd_row_guard_timer: loadable down-counter saturating at 0; ports CLK, RST, clr, load, load_val, zero
module dcd_row_guard_timer #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else cnt <= load ? load_val : clr ? '0 : zero ? cnt : cnt - W'(1);
endmodule

// File: rtl/dcd_frame_scheduler.sv
// dcd_frame_scheduler: per-frame start sequencer for the DCD datapath; strobes in, SEQ/REC start pulses, row/frame counts, sticky errors out
module dcd_frame_scheduler
  import dcd_frame_scheduler_pkg::*;
#(
  parameter int ROW_BITS   = ROW_BITS_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int LEN_BITS   = LEN_BITS_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic                  SINGLE_SHOT,
  input  logic [ROW_BITS-1:0]   ROWS_PER_FRAME,
  input  logic [LEN_BITS-1:0]   ROW_LEN,
  input  logic                  CLR_ERR,
  input  logic                  FSYNC_STROBE,
  input  logic                  R2S_STROBE,
  output logic                  SEQ_START,
  output logic                  REC_START,
  output logic [ROW_BITS-1:0]   ROW_CNT,
  output logic [FRAME_BITS-1:0] FRAME_CNT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR_OVERRUN,
  output logic                  ERR_ROWCOUNT
);
  logic [1:0] state, nxt;
  logic [ROW_BITS-1:0] sh_rows, row_nxt;
  logic [LEN_BITS-1:0] sh_len, t_val;
  logic open, seq_go, rec_go, frm_inc, t_ld, t_clr, t_zero, set_ovr, set_rc;
  dcd_row_guard_timer #(.W(LEN_BITS)) u_tmr (
    .CLK(CLK), .RST(RST), .clr(t_clr), .load(t_ld), .load_val(t_val), .zero(t_zero)
  );
  always_comb begin
    nxt = state;
    open = 1'b0;
    seq_go = 1'b0;
    rec_go = 1'b0;
    frm_inc = 1'b0;
    t_ld = 1'b0;
    t_clr = 1'b0;
    set_ovr = 1'b0;
    set_rc = 1'b0;
    row_nxt = ROW_CNT;
    case (state)
      S_IDLE: nxt = ENABLE ? S_ARMED : S_IDLE;
      S_ARMED:
        if (!ENABLE) begin
          nxt = S_IDLE;
          t_clr = 1'b1;
        end else if (FSYNC_STROBE) begin
          nxt = S_FRAME;
          open = 1'b1;
        end
      S_FRAME:
        if (!ENABLE) begin
          nxt = S_IDLE;
          t_clr = 1'b1;
        end else if (FSYNC_STROBE) begin
          frm_inc = 1'b1;
          set_rc = ROW_CNT != sh_rows;
          if (SINGLE_SHOT) begin
            nxt = S_DONE;
            t_clr = 1'b1;
          end else open = 1'b1;
        end else if (R2S_STROBE) begin
          if (ROW_CNT >= sh_rows) set_rc = 1'b1;
          else if (!t_zero) set_ovr = 1'b1;
          else begin
            seq_go = 1'b1;
            t_ld = 1'b1;
            row_nxt = ROW_CNT + ROW_BITS'(1);
          end
        end
      default: nxt = ENABLE ? S_DONE : S_IDLE;
    endcase
    // A new frame opens with the live config; a coincident R2S becomes row 0
    // of that frame and skips the timer check since the boundary clears it.
    if (open) begin
      rec_go = 1'b1;
      t_clr = 1'b1;
      row_nxt = '0;
      if (R2S_STROBE) begin
        if (ROWS_PER_FRAME == '0) set_rc = 1'b1;
        else begin
          seq_go = 1'b1;
          t_ld = 1'b1;
          row_nxt = ROW_BITS'(1);
        end
      end
    end
    t_val = open ? ROW_LEN : sh_len;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= S_IDLE;
      SEQ_START <= 1'b0;
      REC_START <= 1'b0;
      ROW_CNT <= '0;
      FRAME_CNT <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      ERR_OVERRUN <= 1'b0;
      ERR_ROWCOUNT <= 1'b0;
      sh_rows <= '0;
      sh_len <= '0;
    end else begin
      state <= nxt;
      SEQ_START <= seq_go;
      REC_START <= rec_go;
      ROW_CNT <= row_nxt;
      FRAME_CNT <= FRAME_CNT + FRAME_BITS'(frm_inc);
      BUSY <= nxt == S_ARMED || nxt == S_FRAME;
      DONE <= nxt == S_DONE;
      ERR_OVERRUN <= set_ovr | (ERR_OVERRUN & ~CLR_ERR);
      ERR_ROWCOUNT <= set_rc | (ERR_ROWCOUNT & ~CLR_ERR);
      if (open) begin
        sh_rows <= ROWS_PER_FRAME;
        sh_len <= ROW_LEN;
      end
    end
endmodule

// File: tb/tb_dcd_frame_scheduler.sv
// tb_dcd_frame_scheduler: directed self-checking bench for dcd_frame_scheduler
module tb_dcd_frame_scheduler;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, single_shot = 1'b0, clr_err = 1'b0;
  logic fsync = 1'b0, r2s = 1'b0;
  logic [9:0] rows = '0;
  logic [15:0] row_len = '0;
  logic seq_start, rec_start, busy, done, err_ovr, err_rc;
  logic [9:0] row_cnt;
  logic [15:0] frame_cnt;
  int checks = 0, failures = 0, seq_total = 0, base;
  always #5 clk = ~clk;
  dcd_frame_scheduler dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .SINGLE_SHOT(single_shot),
    .ROWS_PER_FRAME(rows), .ROW_LEN(row_len), .CLR_ERR(clr_err),
    .FSYNC_STROBE(fsync), .R2S_STROBE(r2s), .SEQ_START(seq_start),
    .REC_START(rec_start), .ROW_CNT(row_cnt), .FRAME_CNT(frame_cnt),
    .BUSY(busy), .DONE(done), .ERR_OVERRUN(err_ovr), .ERR_ROWCOUNT(err_rc)
  );
  always @(negedge clk) seq_total <= seq_total + int'(seq_start);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic f, input logic r, input logic c);
    fsync = f;
    r2s = r;
    clr_err = c;
    tick;
    fsync = 1'b0;
    r2s = 1'b0;
    clr_err = 1'b0;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_vec"}, {seq_start, rec_start, busy, done, err_ovr, err_rc}, 0);
    chk({tag, "_row"}, row_cnt, 0);
    chk({tag, "_frm"}, frame_cnt, 0);
  endtask
  initial begin
    repeat (2) tick;
    all_zero("reset");
    rst = 1'b0;
    rows = 10'd4;
    row_len = 16'd0;
    enable = 1'b1;
    tick;
    chk("armed_busy", busy, 1);
    pulse(1, 0, 0);
    chk("open_rec", rec_start, 1);
    chk("open_row", row_cnt, 0);
    base = seq_total;
    for (int i = 0; i < 4; i++) begin
      repeat (19) tick;
      pulse(0, 1, 0);
      chk("row_seq", seq_start, 1);
      chk("row_cnt", row_cnt, i + 1);
    end
    pulse(1, 0, 0);
    chk("close_rec", rec_start, 1);
    chk("close_frm", frame_cnt, 1);
    chk("close_row", row_cnt, 0);
    chk("close_err", {err_ovr, err_rc}, 0);
    chk("seq_total4", seq_total - base, 4);
    row_len = 16'd10;
    pulse(1, 0, 0);
    chk("empty_close_rc", err_rc, 1);
    chk("empty_close_frm", frame_cnt, 2);
    pulse(0, 0, 1);
    chk("clr_rc", err_rc, 0);
    pulse(0, 1, 0);
    chk("guard_first_seq", seq_start, 1);
    repeat (4) tick;
    pulse(0, 1, 0);
    chk("guard_second_seq", seq_start, 0);
    chk("guard_ovr", err_ovr, 1);
    chk("guard_row", row_cnt, 1);
    rows = 10'd3;
    row_len = 16'd0;
    pulse(1, 0, 0);
    chk("f3_frm", frame_cnt, 3);
    pulse(0, 0, 1);
    chk("clr_both", {err_ovr, err_rc}, 0);
    base = seq_total;
    for (int i = 0; i < 3; i++) begin
      tick;
      pulse(0, 1, 0);
    end
    tick;
    pulse(0, 1, 1);
    chk("extra_seq", seq_start, 0);
    chk("set_wins_rc", err_rc, 1);
    tick;
    pulse(0, 1, 0);
    chk("extra_row", row_cnt, 3);
    chk("seq_total3", seq_total - base, 3);
    pulse(1, 0, 0);
    chk("f4_frm", frame_cnt, 4);
    chk("f4_rc_sticky", err_rc, 1);
    pulse(0, 0, 1);
    chk("clr_rc2", err_rc, 0);
    pulse(0, 1, 0);
    tick;
    pulse(0, 1, 0);
    chk("short_row", row_cnt, 2);
    pulse(1, 0, 0);
    chk("short_close_rc", err_rc, 1);
    chk("short_frm", frame_cnt, 5);
    pulse(1, 1, 0);
    chk("simul_rec_seq", {rec_start, seq_start}, 2'b11);
    chk("simul_row", row_cnt, 1);
    chk("simul_frm", frame_cnt, 6);
    rows = 10'd8;
    pulse(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      pulse(0, 1, 0);
    end
    chk("pre_rst_row", row_cnt, 5);
    #2;
    rst = 1'b1;
    #1;
    all_zero("async_rst");
    enable = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("idle_after_rst", {busy, done}, 0);
    single_shot = 1'b1;
    rows = 10'd2;
    enable = 1'b1;
    tick;
    chk("ss_armed", busy, 1);
    pulse(1, 0, 0);
    chk("ss_rec", rec_start, 1);
    pulse(0, 1, 0);
    tick;
    pulse(0, 1, 0);
    chk("ss_row", row_cnt, 2);
    pulse(1, 1, 0);
    chk("ss_done", {busy, done}, 2'b01);
    chk("ss_no_pulse", {rec_start, seq_start}, 0);
    chk("ss_no_err", {err_ovr, err_rc}, 0);
    chk("ss_frm", frame_cnt, 1);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    chk("done_quiet", {rec_start, seq_start, done}, 3'b001);
    enable = 1'b0;
    tick;
    chk("done_to_idle", {busy, done}, 0);
    enable = 1'b1;
    tick;
    chk("rearm", {busy, done}, 2'b10);
    pulse(1, 0, 0);
    chk("rearm_rec", rec_start, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
